// File: rtl/tmds_decoder.sv
// TMDS channel decoder: two-stage decode pipeline plus a word-alignment FSM
// that hunts for blanking runs of control tokens and requests bitslips.
module tmds_decoder #(
  parameter int TOKEN_RUN     = 8,
  parameter int SEARCH_CYCLES = 4096,
  parameter int SLIP_WAIT     = 16
) (
  input  logic       pixel_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] tmds_din,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       bitslip,
  output logic       aligned
);

  localparam int RUN_W = $clog2(TOKEN_RUN + 1);
  localparam int TMR_W = $clog2(SEARCH_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(TOKEN_RUN);
  localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(TOKEN_RUN - 1);
  localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST   = TMR_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Returns {is_token, c1, c0}; only the four exact control codes match.
  function automatic logic [2:0] token_lookup(input logic [9:0] d);
    logic [2:0] r;
    case (d)
      10'b1101010100: r = 3'b100;
      10'b0010101011: r = 3'b101;
      10'b0101010100: r = 3'b110;
      10'b1010101011: r = 3'b111;
      default:        r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] data_decode(input logic [9:0] d);
    logic [7:0] q;
    logic [7:0] r;
    q    = d[9] ? ~d[7:0] : d[7:0];
    r[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = d[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return r;
  endfunction

  logic [9:0]       din_r;
  logic [2:0]       tok_s;
  logic [RUN_W-1:0] run_cnt_r;
  logic [TMR_W-1:0] timer_r;
  logic             run_event_s;
  logic             aligned_next_s;
  logic             bitslip_next_s;
  state_t           state_r;
  state_t           state_next_s;

  assign tok_s = token_lookup(din_r);

  // Stage 1 captures the raw word; stage 2 holds the decoded outputs.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      din_r <= 10'd0;
      dout  <= 8'h00;
      c0    <= 1'b0;
      c1    <= 1'b0;
      de    <= 1'b0;
    end else begin
      din_r <= tmds_din;
      if (tok_s[2]) begin
        de   <= 1'b0;
        c1   <= tok_s[1];
        c0   <= tok_s[0];
        dout <= 8'h00;
      end else begin
        de   <= 1'b1;
        dout <= data_decode(din_r);
      end
    end
  end

  // Run event fires only on the token that brings the count up to TOKEN_RUN.
  always_comb begin
    run_event_s = 1'b0;
    if (tok_s[2] && (state_r != ST_WAIT) && (run_cnt_r == RUN_LAST)) begin
      run_event_s = 1'b1;
    end else begin
      run_event_s = 1'b0;
    end
  end

  // Token run counter, saturating, held cleared while settling after a slip.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_cnt_r <= '0;
    end else if ((state_r == ST_WAIT) || !tok_s[2]) begin
      run_cnt_r <= '0;
    end else if (run_cnt_r != RUN_MAX) begin
      run_cnt_r <= run_cnt_r + RUN_W'(1);
    end
  end

  // Shared timer: search/lock timeout and post-slip settle count.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer_r <= '0;
    end else if (run_event_s || (state_next_s != state_r)) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TMR_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_SEARCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; a run event outranks a coincident timeout.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_SEARCH: begin
        if (run_event_s) begin
          state_next_s = ST_LOCKED;
        end else if (timer_r == SEARCH_LAST) begin
          state_next_s = ST_SLIP;
        end else begin
          state_next_s = ST_SEARCH;
        end
      end
      ST_SLIP: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_r == WAIT_LAST) begin
          state_next_s = ST_SEARCH;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_LOCKED: begin
        if (run_event_s) begin
          state_next_s = ST_LOCKED;
        end else if (timer_r == SEARCH_LAST) begin
          state_next_s = ST_SEARCH;
        end else begin
          state_next_s = ST_LOCKED;
        end
      end
      default: begin
        state_next_s = ST_SEARCH;
      end
    endcase
  end

  // FSM outputs, decoded from the next state so the registers track the state.
  always_comb begin
    aligned_next_s = (state_next_s == ST_LOCKED);
    bitslip_next_s = (state_next_s == ST_SLIP);
  end

  // Registered FSM outputs.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      aligned <= 1'b0;
      bitslip <= 1'b0;
    end else begin
      aligned <= aligned_next_s;
      bitslip <= bitslip_next_s;
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: decode results queued at stimulus time,
// popped by a monitor two cycles later; alignment FSM checked cycle by cycle.
module tb_tmds_decoder;

  logic       pixel_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [9:0] tmds_din  = 10'd0;
  logic [7:0] dout;
  logic       c0, c1, de, bitslip, aligned;

  int          checks   = 0;
  int          failures = 0;
  logic [10:0] exp_q[$];
  logic        vld    = 1'b0;
  logic [1:0]  last_c = 2'b00;
  logic        v1, v2;

  tmds_decoder #(.TOKEN_RUN(8), .SEARCH_CYCLES(64), .SLIP_WAIT(16)) dut (
    .pixel_clk(pixel_clk),
    .sys_rst_n(sys_rst_n),
    .tmds_din (tmds_din),
    .dout     (dout),
    .c0       (c0),
    .c1       (c1),
    .de       (de),
    .bitslip  (bitslip),
    .aligned  (aligned)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Two-cycle valid shadow marks when a driven word reaches the outputs.
  always @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= vld;
      v2 <= v1;
    end
  end

  initial begin : monitor
    logic [10:0] act;
    logic [10:0] exp;
    forever begin
      @(posedge pixel_clk);
      #1;
      if (v2) begin
        act = {de, c1, c0, dout};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_underflow: actual de/c1/c0/dout=%h required none", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            failures++;
            $display("FAIL decode: actual de/c1/c0/dout=%h required %h", act, exp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_token(input logic [9:0] w, input logic [1:0] c);
    @(negedge pixel_clk);
    tmds_din = w;
    vld      = 1'b1;
    last_c   = c;
    exp_q.push_back({1'b0, c, 8'h00});
  endtask

  task automatic drive_data(input logic [9:0] w, input logic [7:0] b);
    @(negedge pixel_clk);
    tmds_din = w;
    vld      = 1'b1;
    exp_q.push_back({1'b1, last_c, b});
  endtask

  task automatic do_reset(input int cycles);
    @(negedge pixel_clk);
    sys_rst_n = 1'b0;
    vld       = 1'b0;
    tmds_din  = 10'd0;
    last_c    = 2'b00;
    exp_q.delete();
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_c", {c1, c0}, 2'b00);
    check("rst_de", de, 1'b0);
    check("rst_bitslip", bitslip, 1'b0);
    check("rst_aligned", aligned, 1'b0);
    repeat (cycles) @(negedge pixel_clk);
    @(posedge pixel_clk);
    #2;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    do_reset(3);

    // Blanking run then data: lock one cycle after the run event.
    for (int i = 0; i < 8; i++) drive_token(10'b1101010100, 2'b00);
    drive_data(10'h100, 8'h00);
    check("align_before_run", aligned, 1'b0);
    drive_data(10'h100, 8'h00);
    check("align_after_run", aligned, 1'b1);

    // All four tokens, then encoded bytes with control bits held at 11.
    drive_token(10'b1101010100, 2'b00);
    drive_token(10'b0010101011, 2'b01);
    drive_token(10'b0101010100, 2'b10);
    drive_token(10'b1010101011, 2'b11);
    drive_data(10'h100, 8'h00);
    drive_data(10'h0AA, 8'h00);
    drive_data(10'h3AA, 8'hFF);
    drive_data(10'h200, 8'hFF);
    drive_data(10'h163, 8'hA5);
    drive_data(10'h39C, 8'hA5);
    drive_data(10'h0C9, 8'hA5);

    // Relock, then starve of tokens until the lock times out.
    for (int i = 0; i < 8; i++) drive_token(10'b1101010100, 2'b00);
    for (int j = 1; j <= 64; j++) drive_data(10'h100, 8'h00);
    drive_data(10'h100, 8'h00);
    check("lock_held", aligned, 1'b1);
    drive_data(10'h100, 8'h00);
    check("lock_lost", aligned, 1'b0);

    // Misaligned stream: slips at cycle 64 and every 81 cycles after.
    do_reset(2);
    for (int n = 0; n < 236; n++) begin
      drive_data(10'h1AA, 8'hFE);
      check($sformatf("search_cycle%0d_bitslip_aligned", n), {bitslip, aligned},
            {((n == 64) || (n == 145) || (n == 226)) ? 1'b1 : 1'b0, 1'b0});
    end

    // Reset lands in the post-slip settle window.
    do_reset(2);
    for (int n = 0; n < 40; n++) begin
      drive_data(10'h1AA, 8'hFE);
      check($sformatf("post_rst_cycle%0d_bitslip_aligned", n), {bitslip, aligned}, 2'b00);
    end

    @(negedge pixel_clk);
    vld = 1'b0;
    repeat (3) @(negedge pixel_clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
